// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: move tick, direction latch, head stepping, game FSM and BCD score
module snake_move_ctrl #(
    parameter int TICK_BASE = 2500000,
    parameter int STEP      = 10,
    parameter int X_MAX     = 630,
    parameter int Y_MAX     = 470,
    parameter int START_X   = 320,
    parameter int START_Y   = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  BTN,
    input  logic [2:0]  SW,
    input  logic        start,
    input  logic        self_hit,
    input  logic        food_eaten,
    output logic [9:0]  head_x,
    output logic [9:0]  head_y,
    output logic [1:0]  dir,
    output logic        move_tick,
    output logic [1:0]  state,
    output logic        game_over,
    output logic [11:0] score
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;

    localparam logic signed [10:0] STP = 11'(STEP);
    localparam logic signed [10:0] XM  = 11'(X_MAX);
    localparam logic signed [10:0] YM  = 11'(Y_MAX);

    state_t st, st_n;
    logic [26:0] cnt, period;
    logic tick_req, wall, hit, step, run;
    logic [1:0] cand, pend_dir;
    logic signed [10:0] dx, dy, nx, ny;
    logic [11:0] score_inc;

    assign state = st;

    always_comb begin
        run = st == RUN;
        period = 27'(TICK_BASE) * (27'd8 - 27'(SW));
        cand = BTN[0] ? 2'b00 : BTN[1] ? 2'b01 : BTN[2] ? 2'b10 : 2'b11;
        dx = pend_dir == 2'b11 ? STP : pend_dir == 2'b10 ? -STP : 11'sd0;
        dy = pend_dir == 2'b01 ? STP : pend_dir == 2'b00 ? -STP : 11'sd0;
        nx = signed'({1'b0, head_x}) + dx;
        ny = signed'({1'b0, head_y}) + dy;
        wall = nx[10] || ny[10] || nx > XM || ny > YM;
        // self_hit outranks a coincident tick, so the head never moves into the body
        hit = run && (self_hit || (tick_req && wall));
        step = run && tick_req && !self_hit && !wall;
        score_inc = score == 12'h999 ? score
                  : score[7:0] == 8'h99 ? {score[11:8] + 4'd1, 8'h00}
                  : score[3:0] == 4'h9 ? {score[11:8], score[7:4] + 4'd1, 4'h0}
                  : score + 12'd1;
        st_n = st;
        if (hit)
            st_n = OVER;
        else if (start)
            st_n = st == IDLE ? RUN : st == RUN ? PAUSE : st == PAUSE ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_x    <= 10'(START_X);
            head_y    <= 10'(START_Y);
            dir       <= 2'b11;
            pend_dir  <= 2'b11;
            cnt       <= '0;
            tick_req  <= 1'b0;
            move_tick <= 1'b0;
            game_over <= 1'b0;
            score     <= '0;
        end else begin
            game_over <= st_n == OVER;
            move_tick <= step;
            // >= rather than == so a faster SW mid-period wraps immediately
            if (run) begin
                tick_req <= cnt >= period - 27'd1;
                cnt <= cnt >= period - 27'd1 ? '0 : cnt + 27'd1;
            end else if (st != PAUSE) begin
                tick_req <= 1'b0;
                cnt <= '0;
            end
            if ((st == IDLE || run) && BTN != 4'd0 && cand != (dir ^ 2'b01))
                pend_dir <= cand;
            if (step) begin
                dir <= pend_dir;
                head_x <= nx[9:0];
                head_y <= ny[9:0];
            end
            if (start && (st == IDLE || st == OVER)) begin
                head_x <= 10'(START_X);
                head_y <= 10'(START_Y);
            end
            if (run && food_eaten)
                score <= score_inc;
            else if (start && st == IDLE)
                score <= '0;
        end
    end
endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
Game-sequencing controller for the snake datapath. It generates the speed-scaled move tick from SW, latches the direction from BTN with reversal rejection, and steps the head coordinates on each tick. It also runs the IDLE/RUN/PAUSE/OVER game FSM and keeps the BCD score. It sits between the board inputs (BTN, SW) and the body/food/render logic in top, and is the sole owner of head_x, head_y and score.

Parameters:
TICK_BASE, 2500000, clock cycles per speed unit (use 4 in simulation)
STEP, 10, pixels moved per tick on the active axis
X_MAX, 630, largest legal head_x
Y_MAX, 470, largest legal head_y
START_X, 320, head_x in IDLE
START_Y, 240, head_y in IDLE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
BTN  in  4  direction buttons, level: [0]=up [1]=down [2]=left [3]=right
SW  in  3  speed select, 0..7
start  in  1  single-cycle pulse: start/pause/resume/restart
self_hit  in  1  head overlaps body, from body logic, level
food_eaten  in  1  single-cycle pulse from food logic
head_x  out  10  head x pixel
head_y  out  10  head y pixel
dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
move_tick  out  1  one-cycle pulse in the cycle head_x/head_y update
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
game_over  out  1  high while in OVER
score  out  12  three BCD digits, 000..999

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, head=(START_X,START_Y), dir=11, pend_dir=11, tick counter=0, move_tick=0, game_over=0, score=000. All other logic is synchronous to the rising edge of clk.
- FSM transitions:
  - IDLE -start-> RUN; clears score and counter and reloads the start head.
  - RUN -start-> PAUSE.
  - PAUSE -start-> RUN.
  - RUN -collision-> OVER.
  - OVER -start-> IDLE.
  - start is ignored in all other cases.
- Tick period P = TICK_BASE*(8-SW) cycles. SW=7 gives TICK_BASE; SW=0 gives 8*TICK_BASE. The counter is at least 27 bits wide.
- Tick counter:
  - Counts only in RUN. It holds in PAUSE and is cleared in IDLE and OVER.
  - When the counter reaches P-1 (or is >= P-1 after an SW change), the counter returns to 0 and a tick is taken the next cycle.
- Direction handling:
  - Each cycle in IDLE or RUN, BTN is priority-decoded (up>down>left>right) into a candidate.
  - The candidate is written to pend_dir unless it is the opposite of the committed dir. BTN=0 leaves pend_dir unchanged.
  - On a tick, dir <= pend_dir. Because of this, two presses between ticks can never produce a reversal.
- Head step on tick:
  - The head moves by STEP along pend_dir, registered, and move_tick=1 for that one cycle.
  - Wall collision: if the step would give x<0, x>X_MAX, y<0 or y>Y_MAX (computed at 11 bits signed), the head does not move, move_tick stays 0, and state becomes OVER.
- self_hit sampled high in RUN moves state to OVER on the next edge. It takes priority over a coincident tick: no move.
- food_eaten in RUN adds 1 in BCD with digit carry. Score saturates at 999. The pulse is ignored outside RUN. A food_eaten and a tick in the same cycle are both applied.
- PAUSE, OVER: head, dir and score are frozen. BTN is ignored in PAUSE and OVER.
- game_over = (state==OVER), registered with state.
- Reset mid-tick or mid-pause returns everything to the reset values immediately. No pulse survives reset.

Test Plan:
- TICK_BASE=4, SW=001, reset then start, BTN=0 -> move_tick every 28 cycles; head_x 320->330->340, head_y=240, dir=11.
- In RUN moving right, BTN=0100 (left) held -> ignored, dir stays 11. Then BTN=0001 (up) -> next tick dir=00, head_y 240->230.
- While moving up: BTN=0100 then BTN=0010 within one tick period -> pend becomes left, then down is rejected. Tick commits left (10); no reversal.
- SW=111, start from IDLE, dir right, run until head_x=630, one more tick -> no move, move_tick=0, state=11, game_over=1. Then start -> IDLE, head=(320,240), score kept until the next start clears it to 000.
- food_eaten pulsed 10 times in RUN -> score=0x010. Preload path to 999 then one more pulse -> stays 0x999. A pulse in PAUSE -> no change.
- Assert start in RUN mid-period -> PAUSE, counter holds. Resume -> next tick arrives after the remaining cycles only. Assert reset during PAUSE -> all outputs at their reset values in the same cycle.
